// File: rtl/bf16_op_issue.sv
// Request front-end for the bfloat16 datapath: registers one add/mul request,
// holds it on the operation-select mux for LATENCY cycles, then returns the captured result.
package bf16_pkg;
    localparam logic [1:0] MODE_ADD = 2'd0;
    localparam logic [1:0] MODE_MUL = 2'd1;
endpackage

module bf16_op_issue
    import bf16_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 7,
    parameter int MODE_WIDTH = 2,
    parameter int LATENCY    = 2,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [MODE_WIDTH-1:0] req_op_i,
    input  logic [DATA_WIDTH-1:0] req_in1_i,
    input  logic [DATA_WIDTH-1:0] req_in2_i,
    output logic [MODE_WIDTH-1:0] op_o,
    output logic [DATA_WIDTH-1:0] in1_o,
    output logic [DATA_WIDTH-1:0] in2_o,
    input  logic [DATA_WIDTH-1:0] out_i,
    input  logic                  overflow_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_overflow_o,
    output logic                  rsp_illegal_o,
    output logic                  busy_o,
    output logic [CNT_WIDTH-1:0]  ovf_cnt_o,
    input  logic                  ovf_clr_i
);

    if (DATA_WIDTH != 1 + EXP_WIDTH + FRAC_WIDTH) begin : g_bad_width
        $error("DATA_WIDTH must equal 1 + EXP_WIDTH + FRAC_WIDTH");
    end
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("LATENCY must be in 1..15");
    end

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       accept, legal, rsp_hs;

    assign legal  = (req_op_i == MODE_WIDTH'(MODE_ADD)) || (req_op_i == MODE_WIDTH'(MODE_MUL));
    // rsp_ready_i feeds ready combinationally so a new request can ride the response handshake
    assign req_ready_o = !rst_i && ((state == IDLE) || (state == RESP && rsp_ready_i));
    assign accept      = req_valid_i && req_ready_o;
    assign rsp_valid_o = (state == RESP);
    assign rsp_hs      = rsp_valid_o && rsp_ready_i;
    assign busy_o      = (state != IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = legal ? EXEC : RESP;
            EXEC: if (cnt == 4'd1) state_nxt = RESP;
            RESP: begin
                if (accept)      state_nxt = legal ? EXEC : RESP;
                else if (rsp_hs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_o           <= '0;
            in1_o          <= '0;
            in2_o          <= '0;
            cnt            <= '0;
            rsp_data_o     <= '0;
            rsp_overflow_o <= 1'b0;
            rsp_illegal_o  <= 1'b0;
        end else if (accept) begin
            op_o  <= req_op_i;
            in1_o <= req_in1_i;
            in2_o <= req_in2_i;
            cnt   <= 4'(LATENCY);
            if (!legal) begin
                rsp_data_o     <= '0;
                rsp_overflow_o <= 1'b0;
                rsp_illegal_o  <= 1'b1;
            end
        end else if (state == EXEC) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
                rsp_data_o     <= out_i;
                rsp_overflow_o <= overflow_i;
                rsp_illegal_o  <= 1'b0;
            end
        end
    end

    // clear beats a same-cycle increment
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                                   ovf_cnt_o <= '0;
        else if (ovf_clr_i)                          ovf_cnt_o <= '0;
        else if (rsp_hs && rsp_overflow_o && ovf_cnt_o != '1)
                                                     ovf_cnt_o <= ovf_cnt_o + CNT_WIDTH'(1);
    end

endmodule

// File: tb/tb_bf16_op_issue.sv
// Directed bench for bf16_op_issue: a stub datapath feeds known results, a scoreboard
// queue holds expected responses and a negedge monitor checks every response handshake.
module tb_bf16_op_issue;
    localparam logic [1:0] ADD = 2'd0;
    localparam logic [1:0] MUL = 2'd1;
    localparam logic [1:0] BAD = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = '0;
    logic [15:0] req_in1 = '0, req_in2 = '0;
    logic [1:0]  op;
    logic [15:0] in1, in2, dp_out;
    logic        dp_ovf;
    logic        rsp_valid, rsp_ready = 1'b1;
    logic [15:0] rsp_data;
    logic        rsp_ovf, rsp_ill, busy, ovf_clr = 1'b0;
    logic [7:0]  ovf_cnt;

    typedef struct packed {
        logic [15:0] data;
        logic        ovf;
        logic        ill;
    } rsp_t;
    rsp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bf16_op_issue dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_in1_i(req_in1), .req_in2_i(req_in2),
        .op_o(op), .in1_o(in1), .in2_o(in2),
        .out_i(dp_out), .overflow_i(dp_ovf),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data), .rsp_overflow_o(rsp_ovf), .rsp_illegal_o(rsp_ill),
        .busy_o(busy), .ovf_cnt_o(ovf_cnt), .ovf_clr_i(ovf_clr)
    );

    // stub datapath with hand-computed bf16 results for the vectors used below
    always_comb begin
        dp_out = 16'h0000;
        dp_ovf = 1'b0;
        if (op == ADD && in1 == 16'h3F80 && in2 == 16'h4000) dp_out = 16'h4040;
        else if (op == MUL && in1 == 16'h4000 && in2 == 16'h4040) dp_out = 16'h40C0;
        else if (op == MUL && in1 == 16'h7F00 && in2 == 16'h7F00) begin
            dp_out = 16'h7F80;
            dp_ovf = 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 32'(rsp_data), 32'hFFFF_FFFF);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp_data", 32'(rsp_data), 32'(e.data));
                check("rsp_ovf",  32'(rsp_ovf),  32'(e.ovf));
                check("rsp_ill",  32'(rsp_ill),  32'(e.ill));
            end
        end
    end

    // drive a request at posedge+1 and hold it until accepted; returns at accept edge +1
    task automatic send(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                        input bit push, input logic [15:0] ed, input logic eo, input logic ei);
        bit done = 0;
        if (push) exp_q.push_back('{data: ed, ovf: eo, ill: ei});
        req_valid = 1'b1; req_op = o; req_in1 = a; req_in2 = b;
        for (int i = 0; i < 50 && !done; i++) begin
            if (req_ready) done = 1;
            @(posedge clk); #1;
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            if (!busy) done = 1;
            else begin @(posedge clk); #1; end
        end
        if (!done) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rsp();
        bit done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            if (rsp_valid) done = 1;
            else begin @(posedge clk); #1; end
        end
        if (!done) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #2;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_cnt",   32'(ovf_cnt),   32'd0);
        check("rst_in1",   32'(in1),       32'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;

        // add with full timing trace
        send(ADD, 16'h3F80, 16'h4000, 1, 16'h4040, 1'b0, 1'b0);
        check("add_op_o",  32'(op),  32'(ADD));
        check("add_in1_o", 32'(in1), 32'h3F80);
        check("add_in2_o", 32'(in2), 32'h4000);
        check("add_ready_exec", 32'(req_ready), 32'd0);
        check("add_valid_c1",   32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("add_valid_c2",   32'(rsp_valid), 32'd0);
        check("add_ready_exec2", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check("add_valid_c3", 32'(rsp_valid), 32'd1);
        check("add_data_c3",  32'(rsp_data),  32'h4040);
        @(posedge clk); #1;
        check("add_idle", 32'(busy), 32'd0);

        // multiply held off by backpressure
        rsp_ready = 1'b0;
        send(MUL, 16'h4000, 16'h4040, 1, 16'h40C0, 1'b0, 1'b0);
        wait_rsp();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_data",  32'(rsp_data),  32'h40C0);
            check("bp_ready", 32'(req_ready), 32'd0);
            check("bp_in1_hold", 32'(in1),    32'h4000);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_idle", 32'(busy), 32'd0);

        // overflow count then clear racing a fourth overflow handshake
        for (int i = 0; i < 3; i++) begin
            send(MUL, 16'h7F00, 16'h7F00, 1, 16'h7F80, 1'b1, 1'b0);
            wait_idle();
        end
        check("ovf_cnt3", 32'(ovf_cnt), 32'd3);
        rsp_ready = 1'b0;
        send(MUL, 16'h7F00, 16'h7F00, 1, 16'h7F80, 1'b1, 1'b0);
        wait_rsp();
        check("ovf_cnt_pre_clr", 32'(ovf_cnt), 32'd3);
        rsp_ready = 1'b1; ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        check("ovf_clr_wins", 32'(ovf_cnt), 32'd0);
        check("ovf_clr_idle", 32'(busy),    32'd0);

        // illegal mode skips EXEC
        send(BAD, 16'h1234, 16'h5678, 1, 16'h0000, 1'b0, 1'b1);
        check("ill_valid", 32'(rsp_valid), 32'd1);
        check("ill_flag",  32'(rsp_ill),   32'd1);
        check("ill_data",  32'(rsp_data),  32'd0);
        check("ill_op_o",  32'(op),        32'(BAD));
        @(posedge clk); #1;
        check("ill_idle", 32'(busy), 32'd0);

        // back-to-back: second accept rides the first response handshake
        send(ADD, 16'h3F80, 16'h4000, 1, 16'h4040, 1'b0, 1'b0);
        send(MUL, 16'h4000, 16'h4040, 1, 16'h40C0, 1'b0, 1'b0);
        check("b2b_busy",  32'(busy),      32'd1);
        check("b2b_valid", 32'(rsp_valid), 32'd0);
        check("b2b_op_o",  32'(op),        32'(MUL));
        wait_idle();

        // reset mid-EXEC discards the request
        send(ADD, 16'h3F80, 16'h4000, 0, 16'h0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("mid_rst_busy",  32'(busy),      32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        check("mid_rst_op",    32'(op),        32'd0);
        check("mid_rst_in1",   32'(in1),       32'd0);
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("post_rst_valid", 32'(rsp_valid), 32'd0);
            @(posedge clk); #1;
        end
        check("post_rst_busy", 32'(busy), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
